// File: rtl/gemm_reader_pkg.sv
// Shared types and constants for the GEMM result reader (C memory drain).
package gemm_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } reader_state_e;

    localparam int FifoDepth      = 2;
    localparam int FifoCountWidth = $clog2(FifoDepth + 1);
    localparam int FifoPtrWidth   = 1;
    localparam int EntryDataWidth = 32;

    // One buffered C element plus the end-of-matrix marker travelling with it.
    typedef struct packed {
        logic                             last;
        logic signed [EntryDataWidth-1:0] data;
    } fifo_entry_t;

    // A new read may go out only if every slot it could land in is guaranteed:
    // entries left after this cycle's pop plus the read already in flight
    // must leave room for one more.
    function automatic logic credit_ok(
        input logic [FifoCountWidth-1:0] count,
        input logic                      inflight,
        input logic                      pop
    );
        logic [FifoCountWidth:0] occupancy_after;
        occupancy_after = {1'b0, count}
                        + {{FifoCountWidth{1'b0}}, inflight}
                        - {{FifoCountWidth{1'b0}}, pop};
        return occupancy_after < (FifoCountWidth + 1)'(FifoDepth);
    endfunction

endpackage

// File: rtl/gemm_reader_fifo.sv
// Two-entry synchronous FIFO buffering C read returns toward the stream side.
// Simultaneous push and pop are legal at any occupancy, including full.
module gemm_reader_fifo
    import gemm_reader_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  fifo_entry_t               wdata,
    output fifo_entry_t               rdata,
    output logic                      full,
    output logic                      empty,
    output logic [FifoCountWidth-1:0] count
);

    fifo_entry_t               mem [FifoDepth];
    logic [FifoPtrWidth-1:0]   wr_ptr;
    logic [FifoPtrWidth-1:0]   rd_ptr;
    logic [FifoCountWidth-1:0] cnt;
    logic                      do_pop;
    logic                      do_push;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FifoCountWidth'(FifoDepth));
    assign count   = cnt;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/gemm_result_reader.sv
// Drains the row-major M x N result region of C memory as a valid/ready stream.
// Optional feature: define GEMM_READER_CHECKSUM_EN to add checksum_o, a wrapping
// sum of every accepted beat of the current drain.
module gemm_result_reader
    import gemm_reader_pkg::*;
#(
    parameter int OutDataWidth  = 32,
    parameter int DataDepth     = 4096,
    parameter int AddrWidth     = 12,
    parameter int SizeAddrWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    input  logic [AddrWidth-1:0]     base_addr_i,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_re_o,
    input  logic [OutDataWidth-1:0]  sram_c_rdata_i,
    output logic [OutDataWidth-1:0]  m_data_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic                     m_last_o,
    output logic                     busy_o,
    output logic                     done_o
`ifdef GEMM_READER_CHECKSUM_EN
    ,
    output logic [OutDataWidth-1:0]  checksum_o
`endif
);

    localparam int TotalWidth = 2 * SizeAddrWidth;

    // The FIFO entry type carries a fixed-width element; catch a mismatched build early.
    if (OutDataWidth != EntryDataWidth || DataDepth != (1 << AddrWidth)) begin : g_param_check
        $error("gemm_result_reader: OutDataWidth must match EntryDataWidth and DataDepth must be 2**AddrWidth");
    end

    reader_state_e             state;
    reader_state_e             state_next;

    logic [TotalWidth-1:0]     start_total;
    logic [TotalWidth-1:0]     total;
    logic [TotalWidth-1:0]     idx;
    logic [AddrWidth-1:0]      base;
    logic [AddrWidth-1:0]      addr_hold;
    logic [AddrWidth-1:0]      issue_addr;
    logic                      start_ok;
    logic                      issue;
    logic                      is_last_idx;
    logic                      inflight;
    logic                      inflight_last;

    fifo_entry_t               fifo_wdata;
    fifo_entry_t               fifo_head;
    logic                      fifo_push;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [FifoCountWidth-1:0] fifo_count;
    logic                      pop;

    assign start_total = TotalWidth'(M_size_i) * TotalWidth'(N_size_i);
    assign start_ok    = (state == IDLE) && start_i;
    assign is_last_idx = (idx == total - TotalWidth'(1));
    assign issue_addr  = base + AddrWidth'(idx);

    assign sram_c_re_o   = issue;
    assign sram_c_addr_o = issue ? issue_addr : addr_hold;

    assign m_valid_o = !fifo_empty;
    assign m_data_o  = fifo_empty ? '0 : fifo_head.data;
    assign m_last_o  = !fifo_empty && fifo_head.last;
    assign pop       = m_valid_o && m_ready_i;

    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and read issue under the credit rule.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_next = (start_total == '0) ? DONE : READ;
            end
            READ: begin
                issue = credit_ok(fifo_count, inflight, pop);
                if (issue && is_last_idx) state_next = DRAIN;
            end
            DRAIN: begin
                // Leave as soon as the final beat is being accepted so done follows it directly.
                if (!inflight && (fifo_empty || (fifo_count == FifoCountWidth'(1) && pop)))
                    state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Drain descriptor, element index, held address and the one-deep read pipe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            total         <= '0;
            base          <= '0;
            idx           <= '0;
            addr_hold     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && is_last_idx;
            if (start_ok) begin
                total <= start_total;
                base  <= base_addr_i;
                idx   <= '0;
            end else if (issue) begin
                idx <= idx + TotalWidth'(1);
            end
            if (issue) addr_hold <= issue_addr;
        end
    end

    // Read data lands one cycle after the strobe; the credit rule keeps a slot free for it.
    assign fifo_push       = inflight && (!fifo_full || pop);
    assign fifo_wdata.last = inflight_last;
    assign fifo_wdata.data = sram_c_rdata_i;

    gemm_reader_fifo u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (fifo_push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef GEMM_READER_CHECKSUM_EN
    logic [OutDataWidth-1:0] checksum;

    // Wrapping sum of accepted beats, restarted by each accepted start.
    always_ff @(posedge clk_i) begin
        if (rst_i)         checksum <= '0;
        else if (start_ok) checksum <= '0;
        else if (pop)      checksum <= checksum + m_data_o;
    end

    assign checksum_o = checksum;
`endif

endmodule

// File: tb/tb_gemm_result_reader.sv
// Self-checking bench for gemm_result_reader against a queue/array reference model.
module tb_gemm_result_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  m_size = '0;
    logic [7:0]  n_size = '0;
    logic [11:0] base_addr = '0;
    logic [11:0] c_addr;
    logic        c_re;
    logic [31:0] c_rdata = '0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic        busy;
    logic        done;
`ifdef GEMM_READER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] mem [4096];
    int n_checks = 0;
    int n_errors = 0;

    gemm_result_reader dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .M_size_i       (m_size),
        .N_size_i       (n_size),
        .base_addr_i    (base_addr),
        .sram_c_addr_o  (c_addr),
        .sram_c_re_o    (c_re),
        .sram_c_rdata_i (c_rdata),
        .m_data_o       (m_data),
        .m_valid_o      (m_valid),
        .m_ready_i      (m_ready),
        .m_last_o       (m_last),
        .busy_o         (busy),
        .done_o         (done)
`ifdef GEMM_READER_CHECKSUM_EN
        ,
        .checksum_o     (checksum)
`endif
    );

    always #5 clk = ~clk;

    // C memory model: one-cycle read latency.
    always @(posedge clk) begin
        if (c_re) c_rdata <= mem[c_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    endtask

    // One complete drain: the expected stream is simply mem[(base+i) mod 4096], i < M*N.
    task automatic run_drain(input string name, input int m, input int n, input int base,
                             input int ready_pct);
        int total = m * n;
        int k = 0;
        int cyc = 0;
        int first_valid = -1;
        int last_cyc = -1;
        int done_cyc = -1;
        int gaps = 0;
        int unstable = 0;
        int extra = 0;
        int issued = 0;
        int max_out = 0;
        bit stalled = 0;
        logic [31:0] held = '0;
        logic [31:0] sum = '0;
        int addr_q[$];

        @(negedge clk);
        m_size = 8'(m);
        n_size = 8'(n);
        base_addr = 12'(base);
        start = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (done_cyc < 0 && cyc < 3000) begin
            m_ready = ($urandom_range(0, 99) < ready_pct);
            #1;
            if (c_re) begin
                addr_q.push_back(int'(c_addr));
                issued++;
            end
            if (stalled && (!m_valid || m_data !== held)) unstable++;
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid && m_ready) begin
                if (k < total) begin
                    check_eq({name, "_data"}, m_data, mem[(base + k) % 4096]);
                    check_eq({name, "_last"}, m_last, (k == total - 1));
                end else begin
                    extra++;
                end
                if (k > 0 && cyc != last_cyc + 1) gaps++;
                last_cyc = cyc;
                sum = sum + m_data;
                k++;
            end
            if (issued - k > max_out) max_out = issued - k;
            if (done) done_cyc = cyc;
            stalled = m_valid && !m_ready;
            held = m_data;
            cyc++;
            @(negedge clk);
        end
        check_eq({name, "_done_seen"}, (done_cyc >= 0), 1);
        check_eq({name, "_beats"}, k, total);
        check_eq({name, "_extra_beats"}, extra, 0);
        check_eq({name, "_reads"}, issued, total);
        for (int i = 0; i < addr_q.size() && i < total; i++)
            check_eq({name, "_addr"}, addr_q[i], (base + i) % 4096);
        check_eq({name, "_stable"}, unstable, 0);
        check_eq({name, "_outstanding_le2"}, (max_out <= 2), 1);
        if (total == 0) begin
            check_eq({name, "_zero_done_cyc"}, done_cyc, 0);
        end else begin
            check_eq({name, "_first_valid_cyc"}, first_valid, 2);
            check_eq({name, "_done_after_last"}, done_cyc, last_cyc + 1);
            if (ready_pct >= 100) check_eq({name, "_gaps"}, gaps, 0);
        end
`ifdef GEMM_READER_CHECKSUM_EN
        check_eq({name, "_checksum"}, checksum, sum);
`endif
        #1;
        check_eq({name, "_done_pulse_once"}, done, 0);
        check_eq({name, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        int k;
        bit poked;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_re", c_re, 0);
        check_eq("rst_addr", c_addr, 0);
        check_eq("rst_valid", m_valid, 0);
        check_eq("rst_data", m_data, 0);
        check_eq("rst_last", m_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic 8x8 drain
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i * 3 - 100);
        run_drain("basic", 8, 8, 0, 100);

        // Backpressure
        fill_random();
        run_drain("bp", 4, 5, int'($urandom_range(0, 4095)), 30);

        // Zero size
        run_drain("zero", 0, 7, 123, 100);

        // Address wrap
        run_drain("wrap", 1, 4, 4094, 100);

        // Randomized shapes, bases and ready rates
        for (int t = 0; t < 3; t++)
            run_drain("rand", int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
                      int'($urandom_range(0, 4095)), int'($urandom_range(40, 100)));

        // Start while busy (ignored), then reset mid-drain
        @(negedge clk);
        m_size = 8'd8;
        n_size = 8'd8;
        base_addr = 12'd200;
        start = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        poked = 0;
        for (int c = 0; c < 300 && k < 10; c++) begin
            #1;
            if (m_valid && m_ready) begin
                check_eq("busy_start_data", m_data, mem[(200 + k) % 4096]);
                k++;
            end
            @(negedge clk);
            if (k == 3 && !poked) begin
                start = 1'b1;
                m_size = 8'd1;
                n_size = 8'd1;
                base_addr = 12'd0;
                poked = 1;
            end else begin
                start = 1'b0;
            end
        end
        check_eq("busy_start_beats", k, 10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("abort_valid", m_valid, 0);
        check_eq("abort_data", m_data, 0);
        check_eq("abort_last", m_last, 0);
        check_eq("abort_re", c_re, 0);
        check_eq("abort_addr", c_addr, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        run_drain("after_rst", 3, 3, 7, 100);

`ifdef GEMM_READER_CHECKSUM_EN
        // Checksum wrap-around
        mem[10] = 32'd1;
        mem[11] = 32'hFFFF_FFFE;
        mem[12] = 32'd3;
        mem[13] = 32'h7FFF_FFFF;
        run_drain("cks", 2, 2, 10, 100);
        check_eq("cks_value", checksum, 32'h8000_0001);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
